load_store_unit: RTL and testbench

Memory-stage load/store unit for the RISC-V core. It consumes the decoder's `mem_w` control word ({funct3, write}) together with the ALU-computed address and store data. It drives a word-addressed data-memory bus with a req/gnt/rvalid handshake, splits misaligned accesses into two word beats, and returns sign- or zero-extended load data to write-back. One access is in flight at a time, and the pipeline stalls on `req_ready_o`.

---
 rtl/lsu_pkg.sv | 31 +++
 rtl/lsu_align.sv | 42 ++++
 rtl/load_store_unit.sv | 182 ++++++++++++++++++
 tb/tb_load_store_unit.sv | 442 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: FSM states, funct3
// encodings for loads and stores, and the funct3 legality check.
package lsu_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE0,
    S_WAIT0,
    S_ISSUE1,
    S_WAIT1,
    S_RESP,
    S_ERR
  } lsu_state_e;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;

  function automatic logic f3_legal(input logic [2:0] f3, input logic we);
    if (we) begin
      return (f3 == SB) || (f3 == SH) || (f3 == SW);
    end
    return (f3 == LB) || (f3 == LH) || (f3 == LW) || (f3 == LBU) || (f3 == LHU);
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: byte-lane mask and split detection, store data
// lane shifting, and load data shifting with sign/zero extension.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] wdata_i,
  input  logic [63:0] rdata_i,
  output logic [7:0]  mask_o,
  output logic        split_o,
  output logic [63:0] st_data_o,
  output logic [31:0] ld_data_o
);

  logic [4:0]  sh;
  logic [31:0] raw;

  always_comb begin
    sh = {off_i, 3'b000};

    case (funct3_i[1:0])
      2'b00:   mask_o = 8'h01 << off_i;
      2'b01:   mask_o = 8'h03 << off_i;
      default: mask_o = 8'h0F << off_i;
    endcase
    split_o = |mask_o[7:4];

    st_data_o = {32'b0, wdata_i} << sh;

    // rdata_i is {beat1, beat0}; only the low word survives the shift
    raw = 32'(rdata_i >> sh);
    case (funct3_i)
      LB:      ld_data_o = {{24{raw[7]}}, raw[7:0]};
      LH:      ld_data_o = {{16{raw[15]}}, raw[15:0]};
      LBU:     ld_data_o = {24'b0, raw[7:0]};
      LHU:     ld_data_o = {16'b0, raw[15:0]};
      default: ld_data_o = raw;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: single outstanding access on a req/gnt/rvalid
// word bus, splitting misaligned accesses into two beats.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [3:0]        mem_w_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       wdata_i,
  input  logic [4:0]        rd_i,
  output logic              dmem_req_o,
  input  logic              dmem_gnt_i,
  output logic [ADDR_W-1:0] dmem_addr_o,
  output logic              dmem_we_o,
  output logic [3:0]        dmem_be_o,
  output logic [31:0]       dmem_wdata_o,
  input  logic              dmem_rvalid_i,
  input  logic [31:0]       dmem_rdata_i,
  output logic              wb_valid_o,
  output logic [4:0]        wb_rd_o,
  output logic [31:0]       wb_data_o,
  output logic              err_o
);

  lsu_state_e        state_q;
  logic [2:0]        f3_q;
  logic              we_q;
  logic [1:0]        off_q;
  logic [31:0]       wdata_q;
  logic [4:0]        rd_q;
  logic [31:0]       rdata0_q;

  logic              dmem_req_q;
  logic [ADDR_W-1:0] dmem_addr_q;
  logic              dmem_we_q;
  logic [3:0]        dmem_be_q;
  logic [31:0]       dmem_wdata_q;
  logic              wb_valid_q;
  logic [4:0]        wb_rd_q;
  logic [31:0]       wb_data_q;
  logic              err_q;

  logic [2:0]        aln_f3;
  logic [1:0]        aln_off;
  logic [31:0]       aln_wdata;
  logic [63:0]       aln_rdata;
  logic [7:0]        aln_mask;
  logic              aln_split;
  logic [63:0]       aln_st;
  logic [31:0]       aln_ld;
  logic [ADDR_W-1:0] beat0_addr_d;
  logic [ADDR_W-1:0] beat1_addr_d;

  // In IDLE the aligner sees the incoming request so beat-0 bus fields can be
  // registered on acceptance; afterwards it works from the captured request.
  always_comb begin
    aln_f3       = (state_q == S_IDLE) ? mem_w_i[3:1] : f3_q;
    aln_off      = (state_q == S_IDLE) ? addr_i[1:0]  : off_q;
    aln_wdata    = (state_q == S_IDLE) ? wdata_i      : wdata_q;
    aln_rdata    = (state_q == S_WAIT1) ? {dmem_rdata_i, rdata0_q} : {32'b0, dmem_rdata_i};
    beat0_addr_d = {addr_i[ADDR_W-1:2], 2'b00};
    beat1_addr_d = dmem_addr_q + ADDR_W'(4);
  end

  lsu_align u_align (
    .funct3_i  (aln_f3),
    .off_i     (aln_off),
    .wdata_i   (aln_wdata),
    .rdata_i   (aln_rdata),
    .mask_o    (aln_mask),
    .split_o   (aln_split),
    .st_data_o (aln_st),
    .ld_data_o (aln_ld)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      f3_q         <= '0;
      we_q         <= 1'b0;
      off_q        <= '0;
      wdata_q      <= '0;
      rd_q         <= '0;
      rdata0_q     <= '0;
      dmem_req_q   <= 1'b0;
      dmem_addr_q  <= '0;
      dmem_we_q    <= 1'b0;
      dmem_be_q    <= '0;
      dmem_wdata_q <= '0;
      wb_valid_q   <= 1'b0;
      wb_rd_q      <= '0;
      wb_data_q    <= '0;
      err_q        <= 1'b0;
    end else begin
      wb_valid_q <= 1'b0;
      err_q      <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req_valid_i) begin
            f3_q    <= mem_w_i[3:1];
            we_q    <= mem_w_i[0];
            off_q   <= addr_i[1:0];
            wdata_q <= wdata_i;
            rd_q    <= rd_i;
            if (!f3_legal(mem_w_i[3:1], mem_w_i[0])) begin
              state_q <= S_ERR;
              err_q   <= 1'b1;
            end else begin
              state_q      <= S_ISSUE0;
              dmem_req_q   <= 1'b1;
              dmem_addr_q  <= beat0_addr_d;
              dmem_we_q    <= mem_w_i[0];
              dmem_be_q    <= aln_mask[3:0];
              dmem_wdata_q <= mem_w_i[0] ? aln_st[31:0] : '0;
            end
          end
        end
        S_ISSUE0: begin
          if (dmem_gnt_i) begin
            dmem_req_q <= 1'b0;
            state_q    <= S_WAIT0;
          end
        end
        S_WAIT0: begin
          if (dmem_rvalid_i) begin
            rdata0_q <= dmem_rdata_i;
            if (aln_split) begin
              state_q      <= S_ISSUE1;
              dmem_req_q   <= 1'b1;
              dmem_addr_q  <= beat1_addr_d;
              dmem_be_q    <= aln_mask[7:4];
              dmem_wdata_q <= we_q ? aln_st[63:32] : '0;
            end else begin
              state_q    <= S_RESP;
              wb_valid_q <= !we_q;
              if (!we_q) begin
                wb_rd_q   <= rd_q;
                wb_data_q <= aln_ld;
              end
            end
          end
        end
        S_ISSUE1: begin
          if (dmem_gnt_i) begin
            dmem_req_q <= 1'b0;
            state_q    <= S_WAIT1;
          end
        end
        S_WAIT1: begin
          if (dmem_rvalid_i) begin
            state_q    <= S_RESP;
            wb_valid_q <= !we_q;
            if (!we_q) begin
              wb_rd_q   <= rd_q;
              wb_data_q <= aln_ld;
            end
          end
        end
        S_RESP:  state_q <= S_IDLE;
        S_ERR:   state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_ready_o  = (state_q == S_IDLE);
  assign dmem_req_o   = dmem_req_q;
  assign dmem_addr_o  = dmem_addr_q;
  assign dmem_we_o    = dmem_we_q;
  assign dmem_be_o    = dmem_be_q;
  assign dmem_wdata_o = dmem_wdata_q;
  assign wb_valid_o   = wb_valid_q;
  assign wb_rd_o      = wb_rd_q;
  assign wb_data_o    = wb_data_q;
  assign err_o        = err_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: byte-addressed memory model, bus responder with
// programmable grant/response delays, directed and randomized accesses.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [3:0]  mem_w_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic [4:0]  rd_i;
  logic        dmem_req_o;
  logic        dmem_gnt_i;
  logic [31:0] dmem_addr_o;
  logic        dmem_we_o;
  logic [3:0]  dmem_be_o;
  logic [31:0] dmem_wdata_o;
  logic        dmem_rvalid_i;
  logic [31:0] dmem_rdata_i;
  logic        wb_valid_o;
  logic [4:0]  wb_rd_o;
  logic [31:0] wb_data_o;
  logic        err_o;

  always #5 clk = ~clk;

  load_store_unit #(.ADDR_W(32)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid_i   (req_valid_i),
    .req_ready_o   (req_ready_o),
    .mem_w_i       (mem_w_i),
    .addr_i        (addr_i),
    .wdata_i       (wdata_i),
    .rd_i          (rd_i),
    .dmem_req_o    (dmem_req_o),
    .dmem_gnt_i    (dmem_gnt_i),
    .dmem_addr_o   (dmem_addr_o),
    .dmem_we_o     (dmem_we_o),
    .dmem_be_o     (dmem_be_o),
    .dmem_wdata_o  (dmem_wdata_o),
    .dmem_rvalid_i (dmem_rvalid_i),
    .dmem_rdata_i  (dmem_rdata_i),
    .wb_valid_o    (wb_valid_o),
    .wb_rd_o       (wb_rd_o),
    .wb_data_o     (wb_data_o),
    .err_o         (err_o)
  );

  int checks = 0;
  int errors = 0;
  int gnt_dly = 0;
  int rv_dly  = 0;
  bit rv_hold = 1'b0;

  logic [7:0] bus_mem [logic [31:0]];
  logic [7:0] ref_mem [logic [31:0]];

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } beat_t;
  beat_t beats[$];

  typedef struct {
    int          wb_lat;
    int          wb_cnt;
    logic [31:0] data;
    logic [4:0]  rd;
    int          err_lat;
    int          rdy_lat;
    bit          saw_req;
  } res_t;

  // ---------------- reference model (byte-level memory semantics) -------------
  function automatic logic [7:0] init_byte(input logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h3C ^ {a[1:0], 6'h15};
  endfunction

  function automatic logic [7:0] bus_byte(input logic [31:0] a);
    return bus_mem.exists(a) ? bus_mem[a] : init_byte(a);
  endfunction

  function automatic logic [7:0] ref_byte(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_byte(a);
  endfunction

  function automatic int size_of(input logic [2:0] f3);
    return (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
  endfunction

  function automatic bit legal(input logic [2:0] f3, input logic we);
    if (we) return f3 inside {3'd0, 3'd1, 3'd2};
    return f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
  endfunction

  function automatic int n_beats(input logic [2:0] f3, input logic [31:0] a);
    return (int'(a[1:0]) + size_of(f3) > 4) ? 2 : 1;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a);
    logic [31:0] raw = '0;
    for (int i = 0; i < size_of(f3); i++) raw[8*i +: 8] = ref_byte(32'(a + i));
    case (f3)
      3'd0:    return {{24{raw[7]}}, raw[7:0]};
      3'd1:    return {{16{raw[15]}}, raw[15:0]};
      default: return raw;
    endcase
  endfunction

  task automatic ref_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
    for (int i = 0; i < size_of(f3); i++) ref_mem[32'(a + i)] = wd[8*i +: 8];
  endtask

  task automatic poke_word(input logic [31:0] a, input logic [31:0] w);
    for (int i = 0; i < 4; i++) begin
      bus_mem[32'(a + i)] = w[8*i +: 8];
      ref_mem[32'(a + i)] = w[8*i +: 8];
    end
  endtask

  // ---------------- bus responder ----------------------------------------------
  initial begin
    int bst, wcnt, rcnt;
    logic [31:0] ba, bwd;
    logic        bwe;
    logic [3:0]  bbe;
    bst = 0; wcnt = 0; rcnt = 0;
    ba = '0; bwd = '0; bwe = 1'b0; bbe = '0;
    dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0; dmem_rdata_i = '0;
    forever begin
      @(posedge clk); #1;
      dmem_gnt_i    = 1'b0;
      dmem_rvalid_i = 1'b0;
      if (bst == 0) begin
        if (dmem_req_o) begin
          if (wcnt < gnt_dly) wcnt++;
          else begin
            dmem_gnt_i = 1'b1;
            wcnt = 0; rcnt = 0; bst = 1;
            ba = dmem_addr_o; bwe = dmem_we_o; bbe = dmem_be_o; bwd = dmem_wdata_o;
            beats.push_back({dmem_addr_o, dmem_we_o, dmem_be_o, dmem_wdata_o});
          end
        end else wcnt = 0;
      end else if (rv_hold || rcnt < rv_dly) begin
        if (!rv_hold) rcnt++;
      end else begin
        dmem_rvalid_i = 1'b1;
        bst = 0;
        if (bwe) begin
          for (int i = 0; i < 4; i++) if (bbe[i]) bus_mem[32'(ba + i)] = bwd[8*i +: 8];
          dmem_rdata_i = $urandom;
        end else begin
          for (int i = 0; i < 4; i++) dmem_rdata_i[8*i +: 8] = bus_byte(32'(ba + i));
        end
      end
    end
  end

  // ---------------- request driving ---------------------------------------------
  task automatic issue_req(input logic [2:0] f3, input logic we, input logic [31:0] a,
                           input logic [31:0] wd, input logic [4:0] rd);
    beats.delete();
    req_valid_i = 1'b1; mem_w_i = {f3, we}; addr_i = a; wdata_i = wd; rd_i = rd;
    @(posedge clk); #1;
    req_valid_i = 1'b0; mem_w_i = 4'($urandom); addr_i = $urandom; wdata_i = $urandom; rd_i = 5'($urandom);
  endtask

  task automatic finish_req(input int start_cyc, output res_t r);
    int cyc = start_cyc;
    r.wb_lat = -1; r.wb_cnt = 0; r.data = '0; r.rd = '0;
    r.err_lat = -1; r.rdy_lat = -1; r.saw_req = 1'b0;
    forever begin
      if (dmem_req_o) r.saw_req = 1'b1;
      if (wb_valid_o) begin r.wb_lat = cyc; r.wb_cnt++; r.data = wb_data_o; r.rd = wb_rd_o; end
      if (err_o) r.err_lat = cyc;
      if (req_ready_o) begin r.rdy_lat = cyc; break; end
      if (cyc >= 300) break;
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic do_access(input logic [2:0] f3, input logic we, input logic [31:0] a,
                           input logic [31:0] wd, input logic [4:0] rd, output res_t r);
    issue_req(f3, we, a, wd, rd);
    finish_req(1, r);
  endtask

  // ---------------- tests --------------------------------------------------------
  task automatic test_reset();
    rst_n = 1'b0; req_valid_i = 1'b0; mem_w_i = '0; addr_i = '0; wdata_i = '0; rd_i = '0;
    #12;
    checks++;
    if (req_ready_o !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", req_ready_o); end
    checks++;
    if ({dmem_req_o, dmem_addr_o, dmem_we_o, dmem_be_o, dmem_wdata_o} !== '0) begin
      errors++; $display("FAIL reset_bus: got req=%b addr=%h we=%b be=%h wdata=%h expected all 0",
                         dmem_req_o, dmem_addr_o, dmem_we_o, dmem_be_o, dmem_wdata_o);
    end
    checks++;
    if ({wb_valid_o, wb_rd_o, wb_data_o, err_o} !== '0) begin
      errors++; $display("FAIL reset_wb: got valid=%b rd=%0d data=%h err=%b expected all 0",
                         wb_valid_o, wb_rd_o, wb_data_o, err_o);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_aligned_store();
    res_t r;
    do_access(3'b010, 1'b1, 32'h100, 32'hDEADBEEF, 5'd0, r);
    ref_store(3'b010, 32'h100, 32'hDEADBEEF);
    checks++;
    if (beats.size() !== 1) begin errors++; $display("FAIL sw_beats: got %0d expected 1", beats.size()); end
    if (beats.size() >= 1) begin
      checks++;
      if (beats[0] !== {32'h100, 1'b1, 4'hF, 32'hDEADBEEF}) begin
        errors++; $display("FAIL sw_beat0: got %h expected %h", beats[0], {32'h100, 1'b1, 4'hF, 32'hDEADBEEF});
      end
    end
    checks++;
    if (r.wb_cnt !== 0) begin errors++; $display("FAIL sw_no_wb: got %0d pulses expected 0", r.wb_cnt); end
    checks++;
    if (r.rdy_lat !== 4) begin errors++; $display("FAIL sw_ready_lat: got %0d expected 4", r.rdy_lat); end
  endtask

  task automatic test_byte_loads();
    res_t r;
    poke_word(32'h100, 32'h80123456);
    do_access(3'b000, 1'b0, 32'h103, 32'h0, 5'd5, r);
    checks++;
    if (r.data !== 32'hFFFFFF80) begin errors++; $display("FAIL lb_data: got %h expected ffffff80", r.data); end
    checks++;
    if (r.wb_lat !== 3 || r.wb_cnt !== 1) begin
      errors++; $display("FAIL lb_latency: got lat %0d count %0d expected lat 3 count 1", r.wb_lat, r.wb_cnt);
    end
    checks++;
    if (r.rd !== 5'd5) begin errors++; $display("FAIL lb_rd: got %0d expected 5", r.rd); end
    do_access(3'b100, 1'b0, 32'h103, 32'h0, 5'd6, r);
    checks++;
    if (r.data !== 32'h00000080) begin errors++; $display("FAIL lbu_data: got %h expected 00000080", r.data); end
  endtask

  task automatic test_misaligned_lw();
    res_t r;
    poke_word(32'h100, 32'h3344AAAA);
    poke_word(32'h104, 32'hBBBB1122);
    do_access(3'b010, 1'b0, 32'h102, 32'h0, 5'd9, r);
    checks++;
    if (beats.size() !== 2) begin errors++; $display("FAIL lw_split_beats: got %0d expected 2", beats.size()); end
    if (beats.size() == 2) begin
      checks++;
      if ({beats[0].addr, beats[0].we, beats[0].be, beats[1].addr, beats[1].we, beats[1].be}
          !== {32'h100, 1'b0, 4'b1100, 32'h104, 1'b0, 4'b0011}) begin
        errors++; $display("FAIL lw_split_addr_be: got %h/%b %h/%b expected 00000100/1100 00000104/0011",
                           beats[0].addr, beats[0].be, beats[1].addr, beats[1].be);
      end
    end
    checks++;
    if (r.data !== 32'h11223344 || r.rd !== 5'd9) begin
      errors++; $display("FAIL lw_split_data: got %h rd %0d expected 11223344 rd 9", r.data, r.rd);
    end
    checks++;
    if (r.wb_lat !== 5) begin errors++; $display("FAIL lw_split_latency: got %0d expected 5", r.wb_lat); end
  endtask

  task automatic test_misaligned_sh();
    res_t r;
    do_access(3'b001, 1'b1, 32'h0FF, 32'h0000ABCD, 5'd0, r);
    ref_store(3'b001, 32'h0FF, 32'h0000ABCD);
    checks++;
    if (beats.size() !== 2) begin errors++; $display("FAIL sh_split_beats: got %0d expected 2", beats.size()); end
    if (beats.size() == 2) begin
      checks++;
      if (beats[0] !== {32'h0FC, 1'b1, 4'b1000, 32'hCD000000}) begin
        errors++; $display("FAIL sh_beat0: got %h expected %h", beats[0], {32'h0FC, 1'b1, 4'b1000, 32'hCD000000});
      end
      checks++;
      if (beats[1] !== {32'h100, 1'b1, 4'b0001, 32'h000000AB}) begin
        errors++; $display("FAIL sh_beat1: got %h expected %h", beats[1], {32'h100, 1'b1, 4'b0001, 32'h000000AB});
      end
    end
  endtask

  task automatic test_gnt_stall();
    res_t r;
    logic [69:0] snap;
    bit stable = 1'b1;
    gnt_dly = 3;
    issue_req(3'b010, 1'b1, 32'h180, 32'h12345678, 5'd0);
    snap = {dmem_req_o, dmem_addr_o, dmem_we_o, dmem_be_o, dmem_wdata_o};
    checks++;
    if (snap !== {1'b1, 32'h180, 1'b1, 4'hF, 32'h12345678}) begin
      errors++; $display("FAIL stall_issue: got %h expected %h", snap, {1'b1, 32'h180, 1'b1, 4'hF, 32'h12345678});
    end
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      if ({dmem_req_o, dmem_addr_o, dmem_we_o, dmem_be_o, dmem_wdata_o} !== snap || req_ready_o !== 1'b0)
        stable = 1'b0;
    end
    checks++;
    if (stable !== 1'b1) begin errors++; $display("FAIL stall_stable: got %b expected 1", stable); end
    finish_req(4, r);
    ref_store(3'b010, 32'h180, 32'h12345678);
    checks++;
    if (r.rdy_lat !== 7) begin errors++; $display("FAIL stall_ready_lat: got %0d expected 7", r.rdy_lat); end
    gnt_dly = 0;
  endtask

  task automatic test_illegal();
    res_t r;
    do_access(3'b011, 1'b0, 32'h100, 32'h0, 5'd3, r);
    checks++;
    if (r.err_lat !== 1 || r.saw_req !== 1'b0 || r.wb_cnt !== 0) begin
      errors++; $display("FAIL illegal_load: got err_lat %0d req %b wb %0d expected 1 0 0", r.err_lat, r.saw_req, r.wb_cnt);
    end
    checks++;
    if (r.rdy_lat !== 2) begin errors++; $display("FAIL illegal_ready_lat: got %0d expected 2", r.rdy_lat); end
    do_access(3'b100, 1'b1, 32'h100, 32'h55555555, 5'd0, r);
    checks++;
    if (r.err_lat !== 1 || r.saw_req !== 1'b0) begin
      errors++; $display("FAIL illegal_store: got err_lat %0d req %b expected 1 0", r.err_lat, r.saw_req);
    end
  endtask

  task automatic test_reset_mid();
    res_t r;
    bit quiet = 1'b1;
    logic [31:0] exp;
    rv_hold = 1'b1;
    issue_req(3'b010, 1'b0, 32'h140, 32'h0, 5'd3);
    @(posedge clk); #1;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({dmem_req_o, dmem_addr_o, dmem_we_o, dmem_be_o, dmem_wdata_o, wb_valid_o, wb_rd_o, wb_data_o, err_o} !== '0
        || req_ready_o !== 1'b1) begin
      errors++; $display("FAIL reset_mid_outputs: got req=%b addr=%h be=%h ready=%b expected 0 0 0 1",
                         dmem_req_o, dmem_addr_o, dmem_be_o, req_ready_o);
    end
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    #2 rv_hold = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      if (wb_valid_o !== 1'b0 || dmem_req_o !== 1'b0 || req_ready_o !== 1'b1) quiet = 1'b0;
    end
    checks++;
    if (quiet !== 1'b1) begin errors++; $display("FAIL stray_rvalid_ignored: got %b expected 1", quiet); end
    exp = ref_load(3'b010, 32'hFFFFFFFE);
    do_access(3'b010, 1'b0, 32'hFFFFFFFE, 32'h0, 5'd12, r);
    checks++;
    if (beats.size() !== 2) begin errors++; $display("FAIL wrap_beats: got %0d expected 2", beats.size()); end
    if (beats.size() == 2) begin
      checks++;
      if ({beats[0].addr, beats[0].be, beats[1].addr, beats[1].be} !== {32'hFFFFFFFC, 4'b1100, 32'h0, 4'b0011}) begin
        errors++; $display("FAIL wrap_addr: got %h/%b %h/%b expected fffffffc/1100 00000000/0011",
                           beats[0].addr, beats[0].be, beats[1].addr, beats[1].be);
      end
    end
    checks++;
    if (r.data !== exp || r.rd !== 5'd12) begin
      errors++; $display("FAIL wrap_data: got %h rd %0d expected %h rd 12", r.data, r.rd, exp);
    end
  endtask

  task automatic test_random();
    res_t r;
    logic [2:0]  f3;
    logic        we;
    logic [31:0] a, wd, exp;
    logic [4:0]  rd;
    int nb, c, exp_rdy;
    for (int n = 0; n < 80; n++) begin
      f3 = 3'($urandom_range(0, 7));
      we = 1'($urandom_range(0, 1));
      a  = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFF8 + 32'($urandom_range(0, 7))
                                       : 32'h200 + 32'($urandom_range(0, 31));
      wd = $urandom;
      rd = 5'($urandom);
      gnt_dly = $urandom_range(0, 2);
      rv_dly  = $urandom_range(0, 2);
      exp = (legal(f3, we) && !we) ? ref_load(f3, a) : 32'h0;
      do_access(f3, we, a, wd, rd, r);
      if (!legal(f3, we)) begin
        checks++;
        if (r.err_lat !== 1 || r.saw_req !== 1'b0 || r.wb_cnt !== 0 || r.rdy_lat !== 2) begin
          errors++; $display("FAIL rand_illegal[%0d]: got err_lat %0d req %b wb %0d rdy %0d expected 1 0 0 2",
                             n, r.err_lat, r.saw_req, r.wb_cnt, r.rdy_lat);
        end
      end else begin
        nb = n_beats(f3, a);
        c  = 2 + gnt_dly + rv_dly;
        exp_rdy = 2 + nb * c;
        if (we) ref_store(f3, a, wd);
        checks++;
        if (beats.size() !== nb || r.err_lat !== -1) begin
          errors++; $display("FAIL rand_beats[%0d]: got %0d beats err_lat %0d expected %0d beats no err",
                             n, beats.size(), r.err_lat, nb);
        end
        checks++;
        if (r.rdy_lat !== exp_rdy) begin
          errors++; $display("FAIL rand_ready_lat[%0d]: got %0d expected %0d", n, r.rdy_lat, exp_rdy);
        end
        checks++;
        if (we ? (r.wb_cnt !== 0)
               : (r.wb_cnt !== 1 || r.wb_lat !== exp_rdy - 1 || r.data !== exp || r.rd !== rd)) begin
          errors++; $display("FAIL rand_wb[%0d]: f3 %0d we %b addr %h got cnt %0d lat %0d data %h rd %0d expected data %h rd %0d",
                             n, f3, we, a, r.wb_cnt, r.wb_lat, r.data, r.rd, exp, rd);
        end
      end
    end
    gnt_dly = 0;
    rv_dly  = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_aligned_store();
    test_byte_loads();
    test_misaligned_lw();
    test_misaligned_sh();
    test_gnt_stall();
    test_illegal();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
